fsm_progress_monitor: RTL

- Downstream observer of a small 2-bit sequencing FSM; consumes its `state`/`out` outputs every cycle.
- Checks three things: legal forward progress, correct `out` pulse placement, and stuck (dead-end) states.
- Emits timestamped error events on a valid/ready stream to the observability log sink and keeps summary counters.
- Catches a design that parks forever in a non-terminal state.

---
 rtl/fsm_mon_pkg.sv | 40 ++++
 rtl/fsm_mon_evt_fifo.sv | 62 ++++++
 rtl/fsm_progress_monitor.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fsm_mon_pkg.sv
// fsm_mon_pkg: shared types for the FSM progress monitor.
// Event records are stored at fixed maximum widths (8-bit state, 32-bit stamp).
// The monitor supports STATE_W <= 8 and CNT_W <= 32.
package fsm_mon_pkg;

    localparam int EVT_DEPTH   = 2;
    localparam int EVT_STATE_W = 8;
    localparam int EVT_STAMP_W = 32;

    typedef enum logic [2:0] {
        EVT_NONE      = 3'd0,
        ILLEGAL_TRANS = 3'd1,
        OUT_MISMATCH  = 3'd2,
        STUCK         = 3'd3
    } evt_code_e;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN,
        STK
    } mon_state_e;

    typedef struct packed {
        evt_code_e               code;
        logic [EVT_STATE_W-1:0]  state;
        logic [EVT_STAMP_W-1:0]  stamp;
    } mon_evt_t;

    // Highest-priority detection wins: ILLEGAL > OUT_MISMATCH > STUCK
    function automatic evt_code_e pick_code(input logic ill, input logic mm);
        if (ill)
            return ILLEGAL_TRANS;
        else if (mm)
            return OUT_MISMATCH;
        else
            return STUCK;
    endfunction

endpackage

// File: rtl/fsm_mon_evt_fifo.sv
// fsm_mon_evt_fifo: small FIFO of monitor events.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module fsm_mon_evt_fifo
    import fsm_mon_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     flush,
    input  logic     push,
    input  mon_evt_t din,
    input  logic     pop,
    output mon_evt_t dout,
    output logic     full,
    output logic     empty
);

    localparam int PW = (EVT_DEPTH > 1) ? $clog2(EVT_DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(EVT_DEPTH - 1);
    localparam logic [PW:0]   DEPTH_C = (PW + 1)'(EVT_DEPTH);

    mon_evt_t        mem [EVT_DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW:0]     count;
    logic            do_pop;
    logic            do_push;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy tracking; flush drops all queued entries
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    // Entry storage, zeroed on reset so the head reads as 0 after rst
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < EVT_DEPTH; i++)
                mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/fsm_progress_monitor.sv
// fsm_progress_monitor: watches a sequencing FSM's state/out for illegal
// transitions, misplaced out pulses and dead-end dwelling; queues timestamped
// events on a valid/ready stream and keeps summary counters.
// Optional: define FSM_MON_COVER_EN to build the visited-state bitmap cov_map.
module fsm_progress_monitor
    import fsm_mon_pkg::*;
#(
    parameter int STATE_W        = 2,
    parameter int STUCK_LIMIT    = 8,
    parameter int PULSE_STATE    = 2,
    parameter int TERMINAL_STATE = 3,
    parameter int TERMINAL_OK    = 0,
    parameter int CNT_W          = 16
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mon_en,
    input  logic                  clr,
    input  logic [STATE_W-1:0]    st_in,
    input  logic                  out_in,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [2:0]            evt_code,
    output logic [STATE_W-1:0]    evt_state,
    output logic [CNT_W-1:0]      evt_stamp,
    output logic                  stuck,
    output logic                  overflow,
    output logic [CNT_W-1:0]      pulse_cnt,
    output logic [7:0]            err_cnt,
    output logic [2**STATE_W-1:0] cov_map
);

    localparam logic [7:0]         LIMIT   = 8'(STUCK_LIMIT);
    localparam logic [STATE_W-1:0] PULSE_S = STATE_W'(PULSE_STATE);
    localparam logic [STATE_W-1:0] TERM_S  = STATE_W'(TERMINAL_STATE);

    mon_state_e         mstate;
    mon_state_e         mstate_nxt;
    logic [STATE_W-1:0] prev;
    logic [7:0]         dwell;
    logic [7:0]         dwell_cur;
    logic [CNT_W-1:0]   ts;
    logic               checking;
    logic               same;
    logic               exp_out;
    logic               terminal;
    logic               ill;
    logic               mm;
    logic               stk;
    logic               pulse_ok;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [1:0]         ndet;
    logic [8:0]         err_sum;
    mon_evt_t           push_evt;
    mon_evt_t           head;
    logic               evt_unused;

    // Detection logic: all checks compare against the registered previous sample
    always_comb begin
        same     = (st_in == prev);
        checking = mon_en && !clr && (mstate == RUN || mstate == STK);
        if (!same)
            dwell_cur = 8'd1;
        else if (dwell == LIMIT)
            dwell_cur = dwell;
        else
            dwell_cur = dwell + 8'd1;
        exp_out  = (st_in == PULSE_S) && (prev != PULSE_S);
        terminal = (TERMINAL_OK != 0) && (st_in == TERM_S);
        ill      = checking && !same && ({1'b0, st_in} != ({1'b0, prev} + 1'b1));
        mm       = checking && (out_in != exp_out);
        stk      = checking && (mstate == RUN) && (dwell_cur == LIMIT) && !terminal;
        pulse_ok = checking && out_in && !mm;
        ndet     = {1'b0, ill} + {1'b0, mm} + {1'b0, stk};
        push     = ill || mm || stk;
        err_sum  = {1'b0, err_cnt} + {7'd0, ndet};
        push_evt       = '0;
        push_evt.code  = pick_code(ill, mm);
        push_evt.state = EVT_STATE_W'(st_in);
        push_evt.stamp = EVT_STAMP_W'(ts);
    end

    // Monitor FSM next state; disabling wins over clr, clr re-arms
    always_comb begin
        mstate_nxt = mstate;
        if (!mon_en) begin
            mstate_nxt = IDLE;
        end else if (clr) begin
            mstate_nxt = ARM;
        end else begin
            case (mstate)
                IDLE:    mstate_nxt = ARM;
                ARM:     mstate_nxt = RUN;
                RUN:     if (stk) mstate_nxt = STK;
                STK:     if (!same) mstate_nxt = RUN;
                default: mstate_nxt = IDLE;
            endcase
        end
    end

    // Monitor FSM state register
    always_ff @(posedge clk) begin
        if (rst)
            mstate <= IDLE;
        else
            mstate <= mstate_nxt;
    end

    // Previous sample and dwell counter; ARM captures the first sample as dwell 1
    always_ff @(posedge clk) begin
        if (rst || !mon_en || clr) begin
            prev  <= '0;
            dwell <= '0;
        end else begin
            case (mstate)
                ARM: begin
                    prev  <= st_in;
                    dwell <= 8'd1;
                end
                RUN, STK: begin
                    prev  <= st_in;
                    dwell <= dwell_cur;
                end
                default: begin
                    prev  <= '0;
                    dwell <= '0;
                end
            endcase
        end
    end

    // Free-running saturating timestamp, unaffected by clr
    always_ff @(posedge clk) begin
        if (rst)
            ts <= '0;
        else if (ts != '1)
            ts <= ts + 1'b1;
    end

    // Summary counters and sticky overflow
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pulse_cnt <= '0;
            err_cnt   <= '0;
            overflow  <= 1'b0;
        end else begin
            if (pulse_ok && pulse_cnt != '1)
                pulse_cnt <= pulse_cnt + 1'b1;
            err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
            if (push && full && !pop)
                overflow <= 1'b1;
        end
    end

    fsm_mon_evt_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (clr),
        .push  (push),
        .din   (push_evt),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign evt_valid  = !empty;
    assign pop        = evt_valid && evt_ready;
    assign evt_code   = head.code;
    assign evt_state  = head.state[STATE_W-1:0];
    assign evt_stamp  = head.stamp[CNT_W-1:0];
    assign evt_unused = ^{head.state, head.stamp};
    assign stuck      = (mstate == STK);

`ifdef FSM_MON_COVER_EN
    logic [2**STATE_W-1:0] cov_q;

    // Visited-state bitmap over every armed or checking cycle
    always_ff @(posedge clk) begin
        if (rst || clr)
            cov_q <= '0;
        else if (mon_en && mstate != IDLE)
            cov_q[st_in] <= 1'b1;
    end

    assign cov_map = cov_q;
`else
    assign cov_map = '0;
`endif

endmodule
